// File: rtl/write_full_block_pkg.sv
// Shared definitions for the write-side FIFO pointer block: default
// address width and Gray-code helpers.
package write_full_block_pkg;

    localparam int ADDR_SIZE_DEFAULT = 3;

    // Operates on zero-extended pointers; callers keep only their low bits.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return (b >> 1) ^ b;
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/write_full_block_if.sv
// Write-side FIFO control bus: request, foreign read pointer and status outputs.
interface write_full_block_if
    import write_full_block_pkg::*;
#(
    parameter int addr_size = ADDR_SIZE_DEFAULT
);

    logic                 write_inc_i;
    logic [addr_size:0]   read_to_write_pointer_i;
    logic                 write_overflow_clear_i;
    logic [addr_size-1:0] write_address_o;
    logic [addr_size:0]   write_pointer_o;
    logic                 write_full_o;
    logic                 write_almost_full_o;
    logic [addr_size:0]   write_level_o;
    logic                 write_overflow_o;

    modport master (
        output write_inc_i,
        output read_to_write_pointer_i,
        output write_overflow_clear_i,
        input  write_address_o,
        input  write_pointer_o,
        input  write_full_o,
        input  write_almost_full_o,
        input  write_level_o,
        input  write_overflow_o
    );

    modport slave (
        input  write_inc_i,
        input  read_to_write_pointer_i,
        input  write_overflow_clear_i,
        output write_address_o,
        output write_pointer_o,
        output write_full_o,
        output write_almost_full_o,
        output write_level_o,
        output write_overflow_o
    );

endinterface

// File: rtl/write_full_block_sync.sv
// Two-flop synchronizer carrying the Gray read pointer into the write clock domain.
module pointer_sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] sync_p0;
    logic [WIDTH-1:0] sync_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= din;
            sync_p1 <= sync_p0;
        end
    end

    assign dout = sync_p1;

endmodule

// File: rtl/write_full_block.sv
// Write-domain half of an async FIFO: binary/Gray write pointer, full and
// almost-full flags, occupancy and sticky overflow, all against a synced read pointer.
module write_full_block
    import write_full_block_pkg::*;
#(
    parameter int addr_size = ADDR_SIZE_DEFAULT
) (
    input logic              write_clock_i,
    input logic              write_reset_i,
    write_full_block_if.slave bus
);

    localparam int PW = addr_size + 1;

    logic [PW-1:0] rptr_sync;
    logic [PW-1:0] bin_q;
    logic [PW-1:0] bin_next;
    logic [PW-1:0] bin_next_inc;
    logic [PW-1:0] gray_next;
    logic [PW-1:0] gray_next_inc;
    logic [PW-1:0] full_target;
    logic [PW-1:0] rbin;
    logic [31:0]   gray_next_w;
    logic [31:0]   gray_next_inc_w;
    logic [31:0]   rbin_w;
    logic          accept;

    logic [PW-1:0] wptr_q;
    logic          full_q;
    logic          afull_q;
    logic [PW-1:0] level_q;
    logic          ovf_q;

    pointer_sync_2ff #(.WIDTH(PW)) u_sync (
        .clk  (write_clock_i),
        .rst  (write_reset_i),
        .din  (bus.read_to_write_pointer_i),
        .dout (rptr_sync)
    );

    assign accept       = bus.write_inc_i & ~full_q;
    assign bin_next     = bin_q + PW'(accept);
    assign bin_next_inc = bin_next + PW'(1);

    assign gray_next_w     = bin2gray(32'(bin_next));
    assign gray_next_inc_w = bin2gray(32'(bin_next_inc));
    assign rbin_w          = gray2bin(32'(rptr_sync));
    assign gray_next       = gray_next_w[PW-1:0];
    assign gray_next_inc   = gray_next_inc_w[PW-1:0];
    assign rbin            = rbin_w[PW-1:0];

    // Full when the write pointer is exactly one lap ahead: top two Gray bits differ.
    assign full_target = rptr_sync ^ (PW'(3) << (addr_size - 1));

    logic unused_hi;
    assign unused_hi = ^{gray_next_w[31:PW], gray_next_inc_w[31:PW], rbin_w[31:PW]};

    always_ff @(posedge write_clock_i or posedge write_reset_i) begin
        if (write_reset_i) begin
            bin_q   <= '0;
            wptr_q  <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            bin_q   <= bin_next;
            wptr_q  <= gray_next;
            full_q  <= (gray_next == full_target);
            afull_q <= (gray_next_inc == full_target);
            level_q <= bin_next - rbin;
            ovf_q   <= (bus.write_inc_i & full_q) | (ovf_q & ~bus.write_overflow_clear_i);
        end
    end

    assign bus.write_address_o     = bin_q[addr_size-1:0];
    assign bus.write_pointer_o     = wptr_q;
    assign bus.write_full_o        = full_q;
    assign bus.write_almost_full_o = afull_q;
    assign bus.write_level_o       = level_q;
    assign bus.write_overflow_o    = ovf_q;

endmodule

// File: tb/tb_write_full_block.sv
// Directed bench for write_full_block (addr_size=3): fill, overflow, read release,
// wrap-around with a tracking read pointer, and asynchronous reset.
module tb_write_full_block;
    import write_full_block_pkg::*;

    localparam int AW = 3;

    logic write_clock_i;
    logic write_reset_i;
    int   total;
    int   bad;

    logic [3:0] gray_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                  4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    write_full_block_if #(.addr_size(AW)) bus ();

    write_full_block #(.addr_size(AW)) dut (
        .write_clock_i (write_clock_i),
        .write_reset_i (write_reset_i),
        .bus           (bus)
    );

    initial write_clock_i = 1'b0;
    always #5 write_clock_i = ~write_clock_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge write_clock_i);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"},  32'(bus.write_address_o),     32'h0);
        check({tag, "_wptr"},  32'(bus.write_pointer_o),     32'h0);
        check({tag, "_full"},  32'(bus.write_full_o),        32'h0);
        check({tag, "_afull"}, 32'(bus.write_almost_full_o), 32'h0);
        check({tag, "_level"}, 32'(bus.write_level_o),       32'h0);
        check({tag, "_ovf"},   32'(bus.write_overflow_o),    32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        write_reset_i                  = 1'b1;
        bus.write_inc_i                = 1'b0;
        bus.read_to_write_pointer_i    = '0;
        bus.write_overflow_clear_i     = 1'b0;

        #2;
        check_all_zero("reset_async");
        tick();
        tick();
        check_all_zero("reset_held");
        write_reset_i = 1'b0;

        // Seven writes: level climbs, almost-full after the seventh.
        bus.write_inc_i = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            check($sformatf("fill_level_%0d", i), 32'(bus.write_level_o), i);
            check($sformatf("fill_full_%0d", i), 32'(bus.write_full_o), 32'h0);
        end
        check("w7_afull", 32'(bus.write_almost_full_o), 32'h1);
        check("w7_addr",  32'(bus.write_address_o),     32'h7);
        check("w7_wptr",  32'(bus.write_pointer_o),     32'h4);

        tick();
        check("w8_full",  32'(bus.write_full_o),        32'h1);
        check("w8_wptr",  32'(bus.write_pointer_o),     32'hC);
        check("w8_level", 32'(bus.write_level_o),       32'h8);
        check("w8_addr",  32'(bus.write_address_o),     32'h0);
        check("w8_afull", 32'(bus.write_almost_full_o), 32'h0);
        check("w8_ovf",   32'(bus.write_overflow_o),    32'h0);

        tick();
        check("w9_wptr",  32'(bus.write_pointer_o),  32'hC);
        check("w9_addr",  32'(bus.write_address_o),  32'h0);
        check("w9_ovf",   32'(bus.write_overflow_o), 32'h1);
        check("w9_full",  32'(bus.write_full_o),     32'h1);

        bus.write_inc_i = 1'b0;
        tick();
        check("ovf_sticky", 32'(bus.write_overflow_o), 32'h1);
        bus.write_overflow_clear_i = 1'b1;
        tick();
        check("ovf_clear", 32'(bus.write_overflow_o), 32'h0);
        bus.write_inc_i = 1'b1;
        tick();
        check("ovf_set_wins", 32'(bus.write_overflow_o), 32'h1);
        check("ovf_set_wptr", 32'(bus.write_pointer_o),  32'hC);
        bus.write_inc_i            = 1'b0;
        bus.write_overflow_clear_i = 1'b0;

        // Read pointer advances by one: visible to the flags on the third edge.
        bus.read_to_write_pointer_i = 4'b0001;
        tick();
        check("rd_e1_full", 32'(bus.write_full_o), 32'h1);
        tick();
        check("rd_e2_full", 32'(bus.write_full_o), 32'h1);
        tick();
        check("rd_e3_full",  32'(bus.write_full_o),        32'h0);
        check("rd_e3_level", 32'(bus.write_level_o),       32'h7);
        check("rd_e3_afull", 32'(bus.write_almost_full_o), 32'h1);

        bus.write_inc_i = 1'b1;
        tick();
        bus.write_inc_i = 1'b0;
        check("refill_full",  32'(bus.write_full_o),    32'h1);
        check("refill_addr",  32'(bus.write_address_o), 32'h1);
        check("refill_wptr",  32'(bus.write_pointer_o), 32'hD);
        check("refill_level", 32'(bus.write_level_o),   32'h8);

        // Overflow again, then reset between clock edges.
        bus.write_inc_i = 1'b1;
        tick();
        check("pre_rst_ovf", 32'(bus.write_overflow_o), 32'h1);
        #2;
        write_reset_i = 1'b1;
        #1;
        check_all_zero("reset_mid");
        bus.write_inc_i             = 1'b0;
        bus.read_to_write_pointer_i = '0;
        tick();
        write_reset_i = 1'b0;

        // Sixteen writes with the reader following right behind.
        bus.write_inc_i = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            check($sformatf("wrap_full_%0d", i), 32'(bus.write_full_o), 32'h0);
            check($sformatf("wrap_wptr_%0d", i), 32'(bus.write_pointer_o), 32'(gray_tab[i % 16]));
            check($sformatf("wrap_level_%0d", i), 32'(bus.write_level_o), (i < 3) ? i : 3);
            bus.read_to_write_pointer_i = gray_tab[i % 16];
        end
        check("wrap_addr", 32'(bus.write_address_o), 32'h0);
        bus.write_inc_i = 1'b0;
        tick();
        tick();
        tick();
        check("drain_level", 32'(bus.write_level_o),       32'h0);
        check("drain_full",  32'(bus.write_full_o),        32'h0);
        check("drain_afull", 32'(bus.write_almost_full_o), 32'h0);
        check("drain_wptr",  32'(bus.write_pointer_o),     32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
